par_to_ser_lanes: RTL and testbench

PAR_TO_SER_LANES -- requirements
Module: par_to_ser_lanes

---
 rtl/par_to_ser_lanes.sv | 120 ++++++++++++
 tb/tb_par_to_ser_lanes.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/par_to_ser_lanes.sv
// Parallel-to-serial shifter with 1-lane or 4-lane output.
// Supports back-to-back words with no idle beat between them.
module par_to_ser_lanes #(
    parameter int WIDTH     = 64,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             load,
    input  logic             bus_wide,
    input  logic [WIDTH-1:0] parallel,
    output logic [3:0]       serial,
    output logic [3:0]       oe,
    output logic             ready,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             wide_q, wide_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       serial_q, serial_d;
    logic [3:0]       oe_q, oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CW-1:0]    last_cnt;
    logic             last_beat;
    logic             accept;

    function automatic logic [3:0] head(input logic [WIDTH-1:0] w,
                                        input logic wd);
        if (MSB_FIRST)
            return wd ? w[WIDTH-1 -: 4] : {3'b111, w[WIDTH-1]};
        else
            return wd ? w[3:0] : {3'b111, w[0]};
    endfunction

    function automatic logic [WIDTH-1:0] tail(input logic [WIDTH-1:0] w,
                                              input logic wd);
        if (MSB_FIRST)
            return wd ? (w << 4) : (w << 1);
        else
            return wd ? (w >> 4) : (w >> 1);
    endfunction

    assign last_cnt  = wide_q ? CW'(WIDTH / 4 - 1) : CW'(WIDTH - 1);
    assign last_beat = (state_q == SHIFT) && (cnt_q == last_cnt);
    assign ready     = (state_q == IDLE) || (last_beat && Enable);
    assign accept    = load && ready;

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        wide_d   = wide_q;
        cnt_d    = cnt_q;
        serial_d = serial_q;
        oe_d     = oe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (accept) begin
            // Streaming accept also closes out the previous word.
            state_d  = SHIFT;
            sh_d     = tail(parallel, bus_wide);
            wide_d   = bus_wide;
            cnt_d    = '0;
            serial_d = head(parallel, bus_wide);
            oe_d     = bus_wide ? 4'b1111 : 4'b0001;
            busy_d   = 1'b1;
            done_d   = (state_q == SHIFT);
        end else if (state_q == SHIFT && Enable) begin
            if (last_beat) begin
                state_d  = IDLE;
                cnt_d    = '0;
                serial_d = 4'b1111;
                oe_d     = 4'b0000;
                busy_d   = 1'b0;
                done_d   = 1'b1;
            end else begin
                cnt_d    = cnt_q + CW'(1);
                serial_d = head(sh_q, wide_q);
                sh_d     = tail(sh_q, wide_q);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q  <= IDLE;
            sh_q     <= '0;
            wide_q   <= 1'b0;
            cnt_q    <= '0;
            serial_q <= 4'b1111;
            oe_q     <= 4'b0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            wide_q   <= wide_d;
            cnt_q    <= cnt_d;
            serial_q <= serial_d;
            oe_q     <= oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign serial = serial_q;
    assign oe     = oe_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_par_to_ser_lanes.sv
// Scoreboard bench: two 16-bit instances (MSB-first and LSB-first)
// share stimulus; each has its own reference model and monitor.
module tb_par_to_ser_lanes;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         Reset = 1'b0;
    logic         Enable = 1'b0;
    logic         load = 1'b0;
    logic         bus_wide = 1'b0;
    logic [W-1:0] parallel = '0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] ser;
        logic [3:0] oe;
        bit         last;
    } beat_t;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int gi,
                       input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s lane%0d t=%0t actual=%h required=%h",
                     nm, gi, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam bit MSB = (g == 0);

        logic [3:0] serial_w, oe_w;
        logic       ready_w, busy_w, done_w;

        beat_t q[$];
        int    rem = 0;
        bit    flush = 1'b0;
        bit    started = 1'b0;
        bit    done_pend = 1'b0;

        par_to_ser_lanes #(.WIDTH(W), .MSB_FIRST(MSB)) u_dut (
            .Clock    (clk),
            .Reset    (Reset),
            .Enable   (Enable),
            .load     (load),
            .bus_wide (bus_wide),
            .parallel (parallel),
            .serial   (serial_w),
            .oe       (oe_w),
            .ready    (ready_w),
            .busy     (busy_w),
            .done     (done_w)
        );

        // Reference model: word -> list of beats, tracked at the edge
        always @(posedge clk) begin
            if (!Reset) begin
                q.delete();
                rem = 0;
                flush = 1'b1;
            end else begin
                bit rdy;
                rdy = (rem == 0) || (rem == 1 && Enable);
                if (rem > 0 && Enable) rem--;
                if (load && rdy) begin
                    int w, n;
                    w = int'(parallel);
                    n = bus_wide ? W / 4 : W;
                    for (int i = 0; i < n; i++) begin
                        beat_t b;
                        int v;
                        if (!bus_wide) begin
                            v = MSB ? (w >> (W - 1 - i)) & 1 : (w >> i) & 1;
                            b.ser = {3'b111, v[0]};
                            b.oe  = 4'b0001;
                        end else begin
                            v = MSB ? (w >> (W - 4 - 4 * i)) & 15
                                    : (w >> (4 * i)) & 15;
                            b.ser = v[3:0];
                            b.oe  = 4'b1111;
                        end
                        b.last = (i == n - 1);
                        q.push_back(b);
                    end
                    rem = n;
                end
            end
        end

        always @(negedge clk) begin
            if (flush) begin
                flush = 1'b0;
                done_pend = 1'b0;
                started = 1'b1;
            end
            if (started) begin
                bit er;
                er = (q.size() == 0) || (q.size() == 1 && Enable);
                chk("ready", g, {3'b000, ready_w}, {3'b000, er});
                chk("busy", g, {3'b000, busy_w}, {3'b000, q.size() != 0});
                chk("done", g, {3'b000, done_w}, {3'b000, done_pend});
                if (q.size() > 0) begin
                    chk("serial", g, serial_w, q[0].ser);
                    chk("oe", g, oe_w, q[0].oe);
                end else begin
                    chk("serial_idle", g, serial_w, 4'b1111);
                    chk("oe_idle", g, oe_w, 4'b0000);
                end
                done_pend = 1'b0;
                if (q.size() > 0 && Enable) begin
                    done_pend = q[0].last;
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic step(input logic r, input logic l, input logic e,
                        input logic wd, input logic [W-1:0] p);
        Reset    = r;
        load     = l;
        Enable   = e;
        bus_wide = wd;
        parallel = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 1, 0, 16'h0000);
    endtask

    initial begin
        repeat (3) step(0, 1, 1, 0, 16'hDEAD);
        idle(2);

        step(1, 1, 1, 0, 16'hF0A5);
        idle(20);

        step(1, 1, 1, 1, 16'hF0A5);
        idle(8);

        step(1, 1, 1, 1, 16'h1234);
        step(1, 0, 1, 0, 16'h0000);
        repeat (3) step(1, 0, 0, 0, 16'h0000);
        idle(6);

        step(1, 1, 1, 0, 16'hAAAA);
        repeat (16) step(1, 1, 1, 0, 16'h5555);
        idle(20);

        step(1, 1, 1, 0, 16'hFFFF);
        repeat (5) step(1, 0, 1, 0, 16'h0000);
        step(0, 1, 1, 1, 16'h0F0F);
        idle(2);
        step(1, 1, 1, 0, 16'hFFFF);
        idle(20);

        step(1, 1, 1, 0, 16'hC3E1);
        repeat (3) step(1, 0, 1, 0, 16'h0000);
        step(1, 1, 1, 1, 16'h9999);
        idle(20);

        for (int i = 0; i < 600; i++) begin
            step(($urandom % 100) != 0,
                 ($urandom % 4) == 0,
                 ($urandom % 4) != 0,
                 1'($urandom),
                 16'($urandom));
        end
        idle(40);

        chk("drain", 0, 4'(g_lane[0].q.size()), 4'd0);
        chk("drain", 1, 4'(g_lane[1].q.size()), 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
